// File: rtl/cha_pkg.sv
// cha_pkg: FSM states, default table entry and derived-width helpers for the CHA bank mapper
package cha_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
    localparam int DEF_IX = 0;
    function automatic int all_w(input int ix_w);
        return ix_w + 1;
    endfunction
    function automatic int tbl_aw(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/cha_strobe_sync.sv
// cha_strobe_sync: two-flop synchroniser and rising-edge detect of PCK1B with the PBUS slice kept aligned
module cha_strobe_sync #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         strobe,
    input  logic [W-1:0] data,
    output logic         rise,
    output logic [W-1:0] data_q
);
    logic [1:0]   s;
    logic         prev;
    logic [W-1:0] d1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= '0;
            prev   <= 1'b0;
            d1     <= '0;
            data_q <= '0;
        end else begin
            s      <= {s[0], strobe};
            prev   <= s[1];
            d1     <= data;
            data_q <= d1;
        end
    end
    assign rise = s[1] & ~prev;
endmodule

// File: rtl/cha_bank_mapper.sv
// cha_bank_mapper: runtime-loadable {IX,MASK} C-ROM bank mapper with settle FSM, chip decode and overflow flag
module cha_bank_mapper
    import cha_pkg::*;
#(
    parameter int GSEL_W     = 8,
    parameter int TBL_DEPTH  = 16,
    parameter int LAT_W      = 7,
    parameter int IX_W       = 12,
    parameter int CHIP_W     = 2,
    parameter int NUM_CHIPS  = 3,
    parameter int SETTLE_CYC = 16,
    localparam int ALL_W     = all_w(IX_W),
    localparam int TBL_AW    = tbl_aw(TBL_DEPTH),
    localparam int ENT_W     = IX_W + LAT_W - 1
) (
    input  logic                      CLK_12M,
    input  logic                      nRESET,
    input  logic                      PCK1B,
    input  logic [LAT_W-1:0]          PBUS_LAT,
    input  logic [GSEL_W-1:0]         GSEL,
    input  logic                      TBL_WE,
    input  logic [TBL_AW-1:0]         TBL_ADDR,
    input  logic [ENT_W-1:0]          TBL_DATA,
    output logic [ALL_W-CHIP_W-2:0]   C_ADDR,
    output logic [2*NUM_CHIPS-1:0]    C_nOE,
    output logic                      READY,
    output logic                      ERR
);
    localparam int CNT_W = $clog2(SETTLE_CYC);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ENT_W-1:0]  DEF_ENTRY = {IX_W'(DEF_IX), {(LAT_W-1){1'b1}}};
    localparam logic [CHIP_W:0]   CHIPS     = (CHIP_W+1)'(NUM_CHIPS);

    logic                 strb;
    logic [LAT_W-1:0]     pbus_q, lat;
    logic [ENT_W-1:0]     tbl [TBL_DEPTH];
    logic [ENT_W-1:0]     ent;
    logic [IX_W-1:0]      ix;
    logic [LAT_W-2:0]     mask;
    logic [GSEL_W-1:0]    gsel_q;
    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 gsel_zero, in_tbl, reload, half, gate;
    logic [IX_W:0]        sum;
    logic [ALL_W-1:0]     full;
    logic [CHIP_W-1:0]    chip;
    logic [2*NUM_CHIPS-1:0] noe;

    cha_strobe_sync #(.W(LAT_W)) u_sync (
        .clk    (CLK_12M),
        .rst_n  (nRESET),
        .strobe (PCK1B),
        .data   (PBUS_LAT),
        .rise   (strb),
        .data_q (pbus_q)
    );

    assign gsel_zero = GSEL == '0;
    assign in_tbl    = GSEL[GSEL_W-1:TBL_AW] == '0;
    assign ent       = in_tbl ? tbl[GSEL[TBL_AW-1:0]] : DEF_ENTRY;
    assign {ix, mask} = ent;
    // Leaving reset or IDLE already starts a full settle, so a change away from 0 is not a reload
    assign reload = (GSEL != gsel_q && gsel_q != '0) ||
                    (TBL_WE && in_tbl && TBL_ADDR == GSEL[TBL_AW-1:0]);

    assign sum  = {1'b0, ix} + (IX_W+1)'(lat[LAT_W-1:1] & mask);
    assign full = {sum[IX_W-1:0], lat[0]};
    assign chip = full[ALL_W-1 -: CHIP_W];
    assign half = full[ALL_W-CHIP_W-1];
    // Gate on the next state so C_nOE and READY change on the same edge
    assign gate = state_n != RUN || sum[IX_W] || {1'b0, chip} >= CHIPS;

    always_comb begin
        noe = '1;
        for (int i = 0; i < NUM_CHIPS; i++)
            if (!gate && chip == CHIP_W'(i)) noe[2*i +: 2] = {~half, half};
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (gsel_zero) state_n = IDLE;
        else if (state == IDLE || reload) begin
            state_n = SETTLE;
            cnt_n   = CNT_LOAD;
        end else if (state == SETTLE) begin
            if (cnt == '0) state_n = RUN;
            else cnt_n = cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            state <= SETTLE;
            cnt   <= CNT_LOAD;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            gsel_q <= '0;
            lat    <= '0;
            C_ADDR <= '0;
            C_nOE  <= '1;
            ERR    <= 1'b0;
            for (int i = 0; i < TBL_DEPTH; i++) tbl[i] <= DEF_ENTRY;
        end else begin
            gsel_q <= GSEL;
            if (strb) lat <= pbus_q;
            C_ADDR <= full[ALL_W-CHIP_W-2:0];
            C_nOE  <= noe;
            ERR    <= !gsel_zero && (ERR || sum[IX_W]);
            if (TBL_WE) tbl[TBL_ADDR] <= TBL_DATA;
        end
    end

    assign READY = state == RUN;
endmodule

// File: tb/tb_cha_bank_mapper.sv
// tb_cha_bank_mapper: directed self-checking bench for the CHA bank mapper
module tb_cha_bank_mapper;
    logic        CLK_12M = 1'b0;
    logic        nRESET;
    logic        PCK1B;
    logic [6:0]  PBUS_LAT;
    logic [7:0]  GSEL;
    logic        TBL_WE;
    logic [3:0]  TBL_ADDR;
    logic [17:0] TBL_DATA;
    logic [9:0]  C_ADDR;
    logic [5:0]  C_nOE;
    logic        READY;
    logic        ERR;
    int checks = 0;
    int errors = 0;

    cha_bank_mapper dut (
        .CLK_12M  (CLK_12M),
        .nRESET   (nRESET),
        .PCK1B    (PCK1B),
        .PBUS_LAT (PBUS_LAT),
        .GSEL     (GSEL),
        .TBL_WE   (TBL_WE),
        .TBL_ADDR (TBL_ADDR),
        .TBL_DATA (TBL_DATA),
        .C_ADDR   (C_ADDR),
        .C_nOE    (C_nOE),
        .READY    (READY),
        .ERR      (ERR)
    );

    always #41 CLK_12M = ~CLK_12M;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_12M);
        #1;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [11:0] ix, input logic [5:0] m);
        TBL_WE = 1'b1;
        TBL_ADDR = a;
        TBL_DATA = {ix, m};
        tick(1);
        TBL_WE = 1'b0;
    endtask

    task automatic strobe(input logic [6:0] v);
        PCK1B = 1'b1;
        PBUS_LAT = v;
        tick(2);
        PCK1B = 1'b0;
        tick(2);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!READY && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (READY !== 1'b1) begin errors++; $display("FAIL %s ready timeout got %b exp 1", name, READY); end
    endtask

    task automatic test_reset;
        nRESET = 1'b0; PCK1B = 1'b0; PBUS_LAT = '0; GSEL = 8'd1;
        TBL_WE = 1'b0; TBL_ADDR = '0; TBL_DATA = '0;
        tick(2);
        checks++;
        if ({C_ADDR, C_nOE, READY, ERR} !== {10'h000, 6'h3F, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_vals got addr=%h noe=%b rdy=%b err=%b exp 000/111111/0/0", C_ADDR, C_nOE, READY, ERR);
        end
        nRESET = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            checks++;
            if (READY !== 1'b0 || C_nOE !== 6'h3F) begin
                errors++; $display("FAIL settle_%0d got rdy=%b noe=%b exp 0/111111", k, READY, C_nOE);
            end
        end
        tick(1);
        checks++;
        if (READY !== 1'b1 || C_nOE !== 6'b111110 || C_ADDR !== 10'h000) begin
            errors++; $display("FAIL first_run got rdy=%b noe=%b addr=%h exp 1/111110/000", READY, C_nOE, C_ADDR);
        end
    endtask

    task automatic test_map;
        write_entry(4'd1, 12'h004, 6'h3F);
        checks++;
        if (READY !== 1'b0) begin errors++; $display("FAIL active_write_settle got %b exp 0", READY); end
        wait_ready("map_settle");
        checks++;
        if (C_ADDR !== 10'h008 || C_nOE !== 6'b111110) begin
            errors++; $display("FAIL map_pre got addr=%h noe=%b exp 008/111110", C_ADDR, C_nOE);
        end
        PCK1B = 1'b1; PBUS_LAT = 7'h05;
        tick(2);
        PCK1B = 1'b0;
        tick(1);
        checks++;
        if (C_ADDR !== 10'h008) begin errors++; $display("FAIL map_latency3 got %h exp 008", C_ADDR); end
        tick(1);
        checks++;
        if (C_ADDR !== 10'h00D || C_nOE !== 6'b111110) begin
            errors++; $display("FAIL map_latency4 got addr=%h noe=%b exp 00D/111110", C_ADDR, C_nOE);
        end
    endtask

    task automatic test_chips;
        write_entry(4'd1, 12'h600, 6'h3F);
        wait_ready("chip1_settle");
        checks++;
        if (C_ADDR !== 10'h005 || C_nOE !== 6'b110111) begin
            errors++; $display("FAIL chip1_hi got addr=%h noe=%b exp 005/110111", C_ADDR, C_nOE);
        end
        write_entry(4'd1, 12'h800, 6'h3F);
        wait_ready("chip2_settle");
        checks++;
        if (C_ADDR !== 10'h005 || C_nOE !== 6'b101111) begin
            errors++; $display("FAIL chip2_lo got addr=%h noe=%b exp 005/101111", C_ADDR, C_nOE);
        end
    endtask

    task automatic test_guard;
        write_entry(4'd1, 12'hC00, 6'h3F);
        wait_ready("chip3_settle");
        strobe(7'h00);
        checks++;
        if (C_nOE !== 6'h3F || ERR !== 1'b0 || READY !== 1'b1) begin
            errors++; $display("FAIL chip3_guard got noe=%b err=%b rdy=%b exp 111111/0/1", C_nOE, ERR, READY);
        end
        write_entry(4'd1, 12'hFFF, 6'h3F);
        wait_ready("fff_settle");
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL no_overflow got %b exp 0", ERR); end
        strobe(7'h7E);
        checks++;
        if (ERR !== 1'b1 || C_nOE !== 6'h3F) begin
            errors++; $display("FAIL overflow got err=%b noe=%b exp 1/111111", ERR, C_nOE);
        end
        write_entry(4'd1, 12'h000, 6'h3F);
        wait_ready("ix0_settle");
        checks++;
        if (ERR !== 1'b1 || C_ADDR !== 10'h07E || C_nOE !== 6'b111110) begin
            errors++; $display("FAIL err_sticky got err=%b addr=%h noe=%b exp 1/07E/111110", ERR, C_ADDR, C_nOE);
        end
    endtask

    task automatic test_gsel_change;
        write_entry(4'd2, 12'h010, 6'h3F);
        checks++;
        if (READY !== 1'b1) begin errors++; $display("FAIL inactive_write got %b exp 1", READY); end
        GSEL = 8'd2;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            checks++;
            if (READY !== 1'b0 || C_nOE !== 6'h3F) begin
                errors++; $display("FAIL gsel_settle_%0d got rdy=%b noe=%b exp 0/111111", k, READY, C_nOE);
            end
        end
        tick(1);
        checks++;
        if (READY !== 1'b1 || C_ADDR !== 10'h09E || C_nOE !== 6'b111110 || ERR !== 1'b1) begin
            errors++; $display("FAIL entry2_map got rdy=%b addr=%h noe=%b err=%b exp 1/09E/111110/1", READY, C_ADDR, C_nOE, ERR);
        end
        GSEL = 8'd0;
        tick(1);
        checks++;
        if (READY !== 1'b0 || C_nOE !== 6'h3F || ERR !== 1'b0) begin
            errors++; $display("FAIL idle got rdy=%b noe=%b err=%b exp 0/111111/0", READY, C_nOE, ERR);
        end
        GSEL = 8'h12;
        wait_ready("default_settle");
        checks++;
        if (C_ADDR !== 10'h07E || C_nOE !== 6'b111110) begin
            errors++; $display("FAIL default_entry got addr=%h noe=%b exp 07E/111110", C_ADDR, C_nOE);
        end
    endtask

    task automatic test_reload;
        GSEL = 8'd0;
        tick(1);
        GSEL = 8'd1;
        tick(11);
        write_entry(4'd1, 12'h004, 6'h3F);
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            checks++;
            if (READY !== 1'b0) begin errors++; $display("FAIL reload_%0d got rdy=%b exp 0", k, READY); end
        end
        tick(1);
        checks++;
        if (READY !== 1'b1 || C_ADDR !== 10'h086 || C_nOE !== 6'b111110) begin
            errors++; $display("FAIL reload_done got rdy=%b addr=%h noe=%b exp 1/086/111110", READY, C_ADDR, C_nOE);
        end
        write_entry(4'd5, 12'h100, 6'h3F);
        tick(3);
        checks++;
        if (READY !== 1'b1) begin errors++; $display("FAIL inactive_idx got %b exp 1", READY); end
    endtask

    task automatic test_async_reset;
        checks++;
        if (C_nOE !== 6'b111110) begin errors++; $display("FAIL pre_reset got %b exp 111110", C_nOE); end
        #20;
        nRESET = 1'b0;
        #1;
        checks++;
        if ({C_ADDR, C_nOE, READY, ERR} !== {10'h000, 6'h3F, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset got addr=%h noe=%b rdy=%b err=%b exp 000/111111/0/0", C_ADDR, C_nOE, READY, ERR);
        end
        tick(1);
        nRESET = 1'b1;
        wait_ready("post_reset_settle");
        strobe(7'h05);
        checks++;
        if (C_ADDR !== 10'h005 || C_nOE !== 6'b111110) begin
            errors++; $display("FAIL table_default got addr=%h noe=%b exp 005/111110", C_ADDR, C_nOE);
        end
    endtask

    initial begin
        test_reset;
        test_map;
        test_chips;
        test_guard;
        test_gsel_change;
        test_reload;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
